// File: rtl/rv32i_dbg_regfile_ctrl.sv
// Debug-access controller for the RV32I register file. It halts the HART at an
// instruction boundary and serves GPR/PC accesses through the normal one-cycle update path.
module rv32i_dbg_regfile_ctrl #(
    parameter bit          RESET_HALTED = 1'b0,
    parameter int unsigned PC_INDEX     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        core_stall,
    input  logic [4:0]  core_rs1_idx,
    input  logic [4:0]  core_rd_idx,
    input  logic [31:0] core_new_rd,
    input  logic        core_update_pc,
    input  logic [31:0] core_new_pc,
    output logic        rf_stall,
    output logic [4:0]  rf_rs1_idx,
    output logic [4:0]  rf_rd_idx,
    output logic [31:0] rf_new_rd,
    output logic        rf_update_pc,
    output logic [31:0] rf_new_pc,
    input  logic [31:0] rf_rs1,
    input  logic [31:0] rf_pc,
    input  logic        dbg_halt_req,
    input  logic        dbg_resume_req,
    output logic        dbg_halted,
    input  logic        dbg_access,
    input  logic        dbg_write,
    input  logic [5:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTED,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam state_t     RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;
    localparam logic [5:0] PC_ADDR     = 6'(PC_INDEX);

    // The register file always adds 4 to whatever PC it loads, so targets are pre-decremented.
    function automatic logic [31:0] pc_pre_inc(input logic [31:0] target);
        return target - 32'd4;
    endfunction

    state_t      state_q, state_d;
    logic        cap_en;
    logic        err_d;
    logic        halted_q;
    logic        ack_q;
    logic        err_q;
    logic [5:0]  addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;
    logic [31:0] read_value;
    logic        addr_is_pc;

    assign addr_is_pc = (addr_p0 == PC_ADDR);

    always_comb begin
        read_value = rf_rs1;
        if (addr_is_pc) begin
            read_value = rf_pc;
        end else if (addr_p0[4:0] == 5'd0) begin
            read_value = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_en  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dbg_halt_req && !core_stall) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // An access takes priority over a resume arriving in the same cycle.
                if (dbg_access) begin
                    if (dbg_addr > PC_ADDR) begin
                        err_d = 1'b1;
                    end else begin
                        cap_en  = 1'b1;
                        state_d = dbg_write ? ST_WRITE : ST_READ;
                    end
                end else if (dbg_resume_req && !dbg_halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_READ:  state_d = ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_HALTED;
            default:  state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        rf_stall     = 1'b1;
        rf_rs1_idx   = addr_p0[4:0];
        rf_rd_idx    = 5'd0;
        rf_new_rd    = wdata_p0;
        rf_update_pc = 1'b0;
        rf_new_pc    = pc_pre_inc(rf_pc);
        case (state_q)
            ST_RUN: begin
                rf_stall     = core_stall;
                rf_rs1_idx   = core_rs1_idx;
                rf_rd_idx    = core_rd_idx;
                rf_new_rd    = core_new_rd;
                rf_update_pc = core_update_pc;
                rf_new_pc    = core_new_pc;
            end
            ST_WRITE: begin
                // Held stalled under reset so an interrupted write never reaches the file.
                if (reset_n) begin
                    rf_stall     = 1'b0;
                    rf_update_pc = 1'b1;
                    if (addr_is_pc) begin
                        rf_new_pc = pc_pre_inc(wdata_p0);
                    end else begin
                        rf_rd_idx = addr_p0[4:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // Stage boundary: state, capture and response registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= RESET_STATE;
            halted_q <= RESET_HALTED;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            rdata_p1 <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d != ST_RUN);
            ack_q    <= (state_q == ST_READ) || (state_q == ST_WRITE);
            err_q    <= err_d;
            if (cap_en) begin
                addr_p0  <= dbg_addr;
                wdata_p0 <= dbg_wdata;
            end
            if (state_q == ST_READ) begin
                rdata_p1 <= read_value;
            end
        end
    end

    assign dbg_halted = halted_q;
    assign dbg_ack    = ack_q;
    assign dbg_err    = err_q;
    assign dbg_rdata  = rdata_p1;

endmodule

// File: tb/tb_rv32i_dbg_regfile_ctrl.sv
// Bench for rv32i_dbg_regfile_ctrl: a small register-file environment plus an
// architectural model (expected GPRs and PC) driven by randomized debug traffic.
module tb_rv32i_dbg_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_stall;
    logic [4:0]  core_rs1_idx;
    logic [4:0]  core_rd_idx;
    logic [31:0] core_new_rd;
    logic        core_update_pc;
    logic [31:0] core_new_pc;
    logic        rf_stall;
    logic [4:0]  rf_rs1_idx;
    logic [4:0]  rf_rd_idx;
    logic [31:0] rf_new_rd;
    logic        rf_update_pc;
    logic [31:0] rf_new_pc;
    logic [31:0] rf_rs1;
    logic [31:0] rf_pc;
    logic        dbg_halt_req;
    logic        dbg_resume_req;
    logic        dbg_halted;
    logic        dbg_access;
    logic        dbg_write;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        dbg_err;

    always #5 clk = ~clk;

    rv32i_dbg_regfile_ctrl #(
        .RESET_HALTED(1'b0),
        .PC_INDEX    (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_stall    (core_stall),
        .core_rs1_idx  (core_rs1_idx),
        .core_rd_idx   (core_rd_idx),
        .core_new_rd   (core_new_rd),
        .core_update_pc(core_update_pc),
        .core_new_pc   (core_new_pc),
        .rf_stall      (rf_stall),
        .rf_rs1_idx    (rf_rs1_idx),
        .rf_rd_idx     (rf_rd_idx),
        .rf_new_rd     (rf_new_rd),
        .rf_update_pc  (rf_update_pc),
        .rf_new_pc     (rf_new_pc),
        .rf_rs1        (rf_rs1),
        .rf_pc         (rf_pc),
        .dbg_halt_req  (dbg_halt_req),
        .dbg_resume_req(dbg_resume_req),
        .dbg_halted    (dbg_halted),
        .dbg_access    (dbg_access),
        .dbg_write     (dbg_write),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_rdata     (dbg_rdata),
        .dbg_ack       (dbg_ack),
        .dbg_err       (dbg_err)
    );

    // Register-file environment driven by the DUT's rf_* outputs.
    logic [31:0] env_regs [32];
    logic [31:0] env_pc;
    logic        env_clr;
    logic        env_load;
    logic [31:0] env_load_pc;

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 32; i++) env_regs[i] <= '0;
        end
        if (env_load) begin
            env_pc <= env_load_pc;
        end else if (!rf_stall) begin
            if (rf_rd_idx != 5'd0) env_regs[rf_rd_idx] <= rf_new_rd;
            env_pc <= (rf_update_pc ? rf_new_pc : env_pc) + 32'd4;
        end
    end

    assign rf_rs1 = (rf_rs1_idx == 5'd0) ? 32'd0 : env_regs[rf_rs1_idx];
    assign rf_pc  = env_pc;

    // Architectural expectations.
    logic [31:0] exp_regs [32];
    logic [31:0] exp_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_op(input logic wr, input logic [5:0] addr, input logic [31:0] wd,
                          input string tag);
        logic [31:0] exp_rd;
        logic [4:0]  gpr;
        gpr    = addr[4:0];
        exp_rd = (addr == 6'd32) ? exp_pc : exp_regs[gpr];
        dbg_access = 1'b1;
        dbg_write  = wr;
        dbg_addr   = addr;
        dbg_wdata  = wd;
        step();
        dbg_access = 1'b0;
        dbg_write  = 1'b0;
        check({tag, " ack_n1"}, dbg_ack, 1'b0);
        if (wr) begin
            check({tag, " wr_stall"}, rf_stall, 1'b0);
            check({tag, " wr_upd_pc"}, rf_update_pc, 1'b1);
            if (addr == 6'd32) begin
                check({tag, " wr_rd_idx"}, rf_rd_idx, 5'd0);
                check({tag, " wr_new_pc"}, rf_new_pc, wd - 32'd4);
            end else begin
                check({tag, " wr_rd_idx"}, rf_rd_idx, gpr);
                check({tag, " wr_new_rd"}, rf_new_rd, wd);
                check({tag, " wr_new_pc"}, rf_new_pc, exp_pc - 32'd4);
            end
        end
        step();
        check({tag, " ack_n2"}, dbg_ack, 1'b1);
        check({tag, " err_n2"}, dbg_err, 1'b0);
        if (!wr) check({tag, " rdata"}, dbg_rdata, exp_rd);
        step();
        check({tag, " ack_n3"}, dbg_ack, 1'b0);
        check({tag, " halted_n3"}, dbg_halted, 1'b1);
        if (wr) begin
            if (addr == 6'd32) exp_pc = wd;
            else if (gpr != 5'd0) exp_regs[gpr] = wd;
        end
        check({tag, " env_pc"}, env_pc, exp_pc);
    endtask

    initial begin
        logic [4:0]  idx;
        logic [31:0] val;

        reset_n        = 1'b0;
        core_stall     = 1'b1;
        core_rs1_idx   = '0;
        core_rd_idx    = '0;
        core_new_rd    = '0;
        core_update_pc = 1'b0;
        core_new_pc    = '0;
        dbg_halt_req   = 1'b0;
        dbg_resume_req = 1'b0;
        dbg_access     = 1'b0;
        dbg_write      = 1'b0;
        dbg_addr       = '0;
        dbg_wdata      = '0;
        env_clr        = 1'b1;
        env_load       = 1'b1;
        env_load_pc    = 32'hF0;
        step();
        check("rst halted", dbg_halted, 1'b0);
        check("rst ack", dbg_ack, 1'b0);
        check("rst err", dbg_err, 1'b0);
        check("rst rdata", dbg_rdata, 32'd0);
        step();
        env_clr  = 1'b0;
        env_load = 1'b0;
        reset_n  = 1'b1;

        // RUN: rf_* mirrors core_* under random traffic.
        for (int i = 0; i < 8; i++) begin
            core_stall     = 1'($urandom);
            core_rs1_idx   = 5'($urandom);
            core_rd_idx    = 5'($urandom);
            core_new_rd    = $urandom;
            core_update_pc = 1'($urandom);
            core_new_pc    = $urandom;
            #1;
            check("run mirror",
                  {rf_stall, rf_rs1_idx, rf_rd_idx, rf_new_rd, rf_update_pc, rf_new_pc},
                  {core_stall, core_rs1_idx, core_rd_idx, core_new_rd, core_update_pc, core_new_pc});
            check("run ack", {dbg_ack, dbg_halted}, 2'b00);
            step();
        end

        core_stall     = 1'b1;
        core_update_pc = 1'b0;
        core_rd_idx    = '0;
        env_clr        = 1'b1;
        env_load       = 1'b1;
        env_load_pc    = 32'hF0;
        step();
        env_clr  = 1'b0;
        env_load = 1'b0;

        // Halt request waits out a stalled pipeline.
        dbg_halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt wait", dbg_halted, 1'b0);
        end
        core_stall  = 1'b0;
        core_rd_idx = 5'd5;
        core_new_rd = 32'h11;
        #1;
        check("halt pass rd_idx", rf_rd_idx, 5'd5);
        step();
        core_stall  = 1'b1;
        core_rd_idx = '0;
        check("halted set", dbg_halted, 1'b1);
        check("halted stall", rf_stall, 1'b1);
        check("core x5 landed", env_regs[5], 32'h11);

        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        exp_regs[5] = 32'h11;
        exp_pc      = 32'h100;
        env_load    = 1'b1;
        env_load_pc = 32'h100;
        step();
        env_load = 1'b0;

        dbg_op(1'b1, 6'd7, 32'hDEADBEEF, "wr x7");
        check("x7 value", env_regs[7], 32'hDEADBEEF);
        dbg_op(1'b0, 6'd7, 32'h0, "rd x7");
        dbg_op(1'b0, 6'd5, 32'h0, "rd x5");

        for (int i = 0; i < 4; i++) begin
            idx = 5'($urandom_range(1, 31));
            val = $urandom;
            dbg_op(1'b1, {1'b0, idx}, val, "rnd wr");
            check("rnd env reg", env_regs[idx], exp_regs[idx]);
            dbg_op(1'b0, {1'b0, idx}, 32'h0, "rnd rd");
        end

        dbg_op(1'b1, 6'd32, 32'h2000, "wr pc");
        dbg_op(1'b0, 6'd32, 32'h0, "rd pc");
        dbg_op(1'b1, 6'd0, 32'h5, "wr x0");
        dbg_op(1'b0, 6'd0, 32'h0, "rd x0");

        // Out-of-range address: error pulse, no ack, no change.
        dbg_access = 1'b1;
        dbg_addr   = 6'd40;
        dbg_write  = 1'b1;
        dbg_wdata  = 32'hBAD;
        step();
        dbg_access = 1'b0;
        check("err pulse", {dbg_err, dbg_ack}, 2'b10);
        step();
        check("err end", {dbg_err, dbg_ack}, 2'b00);
        step();
        check("err no ack", dbg_ack, 1'b0);
        check("err pc kept", env_pc, exp_pc);
        check("err x7 kept", env_regs[7], exp_regs[7]);

        // Resume while halt_req still high is ignored.
        dbg_resume_req = 1'b1;
        step();
        dbg_resume_req = 1'b0;
        step();
        check("resume ignored", dbg_halted, 1'b1);

        dbg_halt_req   = 1'b0;
        dbg_resume_req = 1'b1;
        core_stall     = 1'b0;
        step();
        dbg_resume_req = 1'b0;
        check("resumed", dbg_halted, 1'b0);
        check("resume pc", env_pc, 32'h2000);
        step();
        step();
        step();
        exp_pc = 32'h200C;
        check("run pc advance", env_pc, exp_pc);

        core_stall = 1'b1;
        dbg_access = 1'b1;
        dbg_write  = 1'b0;
        dbg_addr   = 6'd7;
        step();
        dbg_access = 1'b0;
        check("run access n1", {dbg_ack, dbg_err}, 2'b00);
        step();
        check("run access n2", {dbg_ack, dbg_err}, 2'b00);

        dbg_halt_req = 1'b1;
        core_stall   = 1'b0;
        step();
        core_stall = 1'b1;
        exp_pc     = exp_pc + 32'd4;
        check("rehalt", dbg_halted, 1'b1);

        // Reset during WRITE: nothing reaches the register file.
        dbg_access = 1'b1;
        dbg_write  = 1'b1;
        dbg_addr   = 6'd9;
        dbg_wdata  = 32'hA5A5A5A5;
        step();
        dbg_access   = 1'b0;
        dbg_halt_req = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("rst wr stall", rf_stall, 1'b1);
        step();
        reset_n = 1'b1;
        check("rst wr halted", dbg_halted, 1'b0);
        check("rst wr ack", dbg_ack, 1'b0);
        step();
        check("rst wr ack2", dbg_ack, 1'b0);
        check("rst wr x9", env_regs[9], exp_regs[9]);
        check("rst wr pc", env_pc, exp_pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
